cache_axi_refill: RTL and testbench

- Memory-side engine for the cache: services `miss` / `write_back` requests by driving a simplified AXI4 master.
- Evicts the dirty line (`cacheline_old` to `waddr`) with a write burst, then fetches the new line from `raddr` with a read burst.
- Presents the assembled `cacheline_new` together with a one-cycle `refresh` pulse.
- Sits between the cache and the AXI crossbar; one transaction in flight at a time.

---
 rtl/cache_axi_refill.sv | 212 +++++++++++++++++++++
 tb/tb_cache_axi_refill.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_axi_refill.sv
// Cache refill engine: evicts a dirty victim line with an AXI4 write burst, then
// fetches the requested line with an AXI4 read burst. CACHE_AXI_ERR_EN enables bus_err.
module cache_axi_refill #(
    parameter int unsigned CACHELINE_WD = 512
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    miss,
    input  logic [31:0]             raddr,
    input  logic                    write_back,
    input  logic [31:0]             waddr,
    input  logic [CACHELINE_WD-1:0] cacheline_old,
    output logic                    refresh,
    output logic [CACHELINE_WD-1:0] cacheline_new,
    output logic                    busy,
    output logic                    arvalid,
    input  logic                    arready,
    output logic [31:0]             araddr,
    output logic [7:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    input  logic                    rvalid,
    output logic                    rready,
    input  logic [31:0]             rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [31:0]             awaddr,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic                    wvalid,
    input  logic                    wready,
    output logic [31:0]             wdata,
    output logic [3:0]              wstrb,
    output logic                    wlast,
    input  logic                    bvalid,
    output logic                    bready,
    input  logic [1:0]              bresp,
    output logic                    bus_err
);
    localparam int unsigned BEATS     = CACHELINE_WD / 32;
    localparam int unsigned OFFSET_WD = $clog2(CACHELINE_WD / 8);
    localparam int unsigned IDX_WD    = $clog2(BEATS);
    localparam int unsigned CNT_WD    = IDX_WD + 1;
    localparam logic [CNT_WD-1:0] LAST_BEAT = CNT_WD'(BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_WD-1:0]       cnt_q, cnt_d;
    logic [31:0]             waddr_q, waddr_d;
    logic [31:0]             raddr_q, raddr_d;
    logic [CACHELINE_WD-1:0] line_old_q, line_old_d;
    logic [CACHELINE_WD-1:0] line_new_q, line_new_d;
    logic [31:0]             wdata_q, wdata_d;
    logic                    wlast_q, wlast_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    bready_q, bready_d;
    logic                    arvalid_q, arvalid_d;
    logic                    rready_q, rready_d;
    logic                    refresh_q, refresh_d;
    logic                    busy_q, busy_d;
    logic                    err_q, err_d;

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        waddr_d    = waddr_q;
        raddr_d    = raddr_q;
        line_old_d = line_old_q;
        line_new_d = line_new_q;
        err_d      = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (miss) begin
                    raddr_d = {raddr[31:OFFSET_WD], {OFFSET_WD{1'b0}}};
                    if (write_back) begin
                        waddr_d    = {waddr[31:OFFSET_WD], {OFFSET_WD{1'b0}}};
                        line_old_d = cacheline_old;
                        state_d    = S_AW;
                    end else begin
                        state_d = S_AR;
                    end
                end
            end
            S_AW: begin
                if (awready) begin
                    state_d = S_W;
                    cnt_d   = '0;
                end
            end
            S_W: begin
                if (wready) begin
                    if (cnt_q == LAST_BEAT) state_d = S_B;
                    else                    cnt_d   = cnt_q + CNT_WD'(1);
                end
            end
            S_B: begin
                if (bvalid) state_d = S_AR;
            end
            S_AR: begin
                if (arready) begin
                    state_d = S_R;
                    cnt_d   = '0;
                end
            end
            S_R: begin
                if (rvalid) begin
                    // Counter saturates at BEATS so overrun beats are dropped
                    if (!cnt_q[IDX_WD]) begin
                        line_new_d[32*int'(cnt_q[IDX_WD-1:0]) +: 32] = rdata;
                        cnt_d = cnt_q + CNT_WD'(1);
                    end
                    if (rlast) state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
`ifdef CACHE_AXI_ERR_EN
        if (state_q == S_B && bvalid && bresp != 2'b00) err_d = 1'b1;
        if (state_q == S_R && rvalid &&
            (rresp != 2'b00 || (rlast != (cnt_q == LAST_BEAT)))) err_d = 1'b1;
`endif
        awvalid_d = (state_d == S_AW);
        wvalid_d  = (state_d == S_W);
        wlast_d   = (state_d == S_W) && (cnt_d == LAST_BEAT);
        wdata_d   = line_old_d[32*int'(cnt_d[IDX_WD-1:0]) +: 32];
        bready_d  = (state_d == S_B);
        arvalid_d = (state_d == S_AR);
        rready_d  = (state_d == S_R);
        refresh_d = (state_d == S_DONE);
        busy_d    = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            waddr_q    <= '0;
            raddr_q    <= '0;
            line_old_q <= '0;
            line_new_q <= '0;
            wdata_q    <= '0;
            wlast_q    <= 1'b0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            refresh_q  <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            waddr_q    <= waddr_d;
            raddr_q    <= raddr_d;
            line_old_q <= line_old_d;
            line_new_q <= line_new_d;
            wdata_q    <= wdata_d;
            wlast_q    <= wlast_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            bready_q   <= bready_d;
            arvalid_q  <= arvalid_d;
            rready_q   <= rready_d;
            refresh_q  <= refresh_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign refresh       = refresh_q;
    assign cacheline_new = line_new_q;
    assign busy          = busy_q;
    assign arvalid       = arvalid_q;
    assign araddr        = raddr_q;
    assign arlen         = 8'(BEATS - 1);
    assign arsize        = 3'b010;
    assign arburst       = 2'b01;
    assign rready        = rready_q;
    assign awvalid       = awvalid_q;
    assign awaddr        = waddr_q;
    assign awlen         = 8'(BEATS - 1);
    assign awsize        = 3'b010;
    assign awburst       = 2'b01;
    assign wvalid        = wvalid_q;
    assign wdata         = wdata_q;
    assign wstrb         = 4'hF;
    assign wlast         = wlast_q;
    assign bready        = bready_q;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{raddr[OFFSET_WD-1:0], waddr[OFFSET_WD-1:0]};

`ifdef CACHE_AXI_ERR_EN
    assign bus_err = err_q;
`else
    // Responses are not inspected without the error option
    logic unused_resp;
    assign unused_resp = ^{rresp, bresp, err_q};
    assign bus_err     = 1'b0;
`endif

endmodule

// File: tb/tb_cache_axi_refill.sv
// Scoreboard bench for cache_axi_refill: directed evict/fill transactions pushed to
// expectation queues, checked by a negedge monitor on every handshake and refresh.
`timescale 1ns/1ps
module tb_cache_axi_refill;
    localparam int unsigned LW = 512;
    localparam int unsigned NB = LW / 32;
`ifdef CACHE_AXI_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          miss = 1'b0, write_back = 1'b0;
    logic [31:0]   raddr = '0, waddr = '0;
    logic [LW-1:0] cacheline_old = '0;
    logic          refresh, busy, bus_err;
    logic [LW-1:0] cacheline_new;
    logic          arvalid, arready = 1'b0;
    logic [31:0]   araddr;
    logic [7:0]    arlen, awlen;
    logic [2:0]    arsize, awsize;
    logic [1:0]    arburst, awburst;
    logic          rvalid = 1'b0, rready, rlast = 1'b0;
    logic [31:0]   rdata = '0;
    logic [1:0]    rresp = '0, bresp = '0;
    logic          awvalid, awready = 1'b0;
    logic [31:0]   awaddr;
    logic          wvalid, wready = 1'b0, wlast;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic          bvalid = 1'b0, bready;

    int checks = 0;
    int errors = 0;

    logic [31:0]   exp_aw[$];
    logic [32:0]   exp_w[$];
    logic [31:0]   exp_ar[$];
    logic [LW-1:0] exp_line[$];

    cache_axi_refill #(.CACHELINE_WD(LW)) dut (
        .clk(clk), .resetn(resetn), .miss(miss), .raddr(raddr),
        .write_back(write_back), .waddr(waddr), .cacheline_old(cacheline_old),
        .refresh(refresh), .cacheline_new(cacheline_new), .busy(busy),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arburst(arburst), .rvalid(rvalid), .rready(rready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .awvalid(awvalid),
        .awready(awready), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .wvalid(wvalid), .wready(wready), .wdata(wdata),
        .wstrb(wstrb), .wlast(wlast), .bvalid(bvalid), .bready(bready),
        .bresp(bresp), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] val);
        checks++;
        errors++;
        $display("FAIL %s: got %0h expected no event", name, val);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops expectations on every handshake, checks stability under stall
    logic        wb_pending = 1'b0, refresh_prev = 1'b0;
    logic        aw_stall = 1'b0, w_stall = 1'b0, ar_stall = 1'b0;
    logic [31:0] aw_hold, w_hold, ar_hold;
    int          refresh_cnt = 0;
    always @(negedge clk) begin
        if (!resetn) begin
            wb_pending = 1'b0; refresh_prev = 1'b0;
            aw_stall = 1'b0; w_stall = 1'b0; ar_stall = 1'b0;
        end else begin
            if (aw_stall) begin
                chk("awvalid_held", LW'(awvalid), LW'(1));
                chk("awaddr_stable", LW'(awaddr), LW'(aw_hold));
            end
            if (w_stall) chk("wdata_stable", LW'(wdata), LW'(w_hold));
            if (ar_stall) begin
                chk("arvalid_held", LW'(arvalid), LW'(1));
                chk("araddr_stable", LW'(araddr), LW'(ar_hold));
            end
            if (awvalid) chk("w_during_aw", LW'(wvalid), LW'(0));
            if (awvalid && awready) begin
                if (exp_aw.size() == 0) fail_now("aw_unexpected", awaddr);
                else begin
                    chk("awaddr", LW'(awaddr), LW'(exp_aw.pop_front()));
                    chk("awlen", LW'(awlen), LW'(8'd15));
                    chk("awsize_burst", LW'({awsize, awburst}), LW'(5'b010_01));
                    wb_pending = 1'b1;
                end
            end
            if (wvalid && wready) begin
                if (exp_w.size() == 0) fail_now("w_unexpected", wdata);
                else begin
                    logic [32:0] e;
                    e = exp_w.pop_front();
                    chk("wdata", LW'(wdata), LW'(e[31:0]));
                    chk("wlast", LW'(wlast), LW'(e[32]));
                    chk("wstrb", LW'(wstrb), LW'(4'hF));
                end
            end
            if (bvalid && bready) wb_pending = 1'b0;
            if (arvalid) chk("ar_before_b", LW'(wb_pending), LW'(0));
            if (arvalid && arready) begin
                if (exp_ar.size() == 0) fail_now("ar_unexpected", araddr);
                else begin
                    chk("araddr", LW'(araddr), LW'(exp_ar.pop_front()));
                    chk("arlen", LW'(arlen), LW'(8'd15));
                    chk("arsize_burst", LW'({arsize, arburst}), LW'(5'b010_01));
                end
            end
            if (refresh) begin
                chk("refresh_width", LW'(refresh_prev), LW'(0));
                refresh_cnt++;
                if (exp_line.size() == 0) fail_now("refresh_unexpected", cacheline_new[31:0]);
                else chk("cacheline_new", cacheline_new, exp_line.pop_front());
            end
            refresh_prev = refresh;
            aw_stall = awvalid && !awready; aw_hold = awaddr;
            w_stall  = wvalid && !wready;   w_hold  = wdata;
            ar_stall = arvalid && !arready; ar_hold = araddr;
        end
    end

    // One full miss: optional eviction, then fill; the in-bench slave answers
    task automatic run_txn(input bit wb, input logic [31:0] ra, input logic [31:0] ra_exp,
                           input logic [31:0] wa, input logic [31:0] wa_exp,
                           input int wbase, input int rbase, input int stall,
                           input bit gaps, input int err_beat);
        logic [LW-1:0] old_line, new_line;
        bit done;
        int n;
        for (int i = 0; i < NB; i++) begin
            old_line[32*i +: 32] = 32'(wbase + i);
            new_line[32*i +: 32] = 32'(rbase + i);
        end
        if (wb) begin
            exp_aw.push_back(wa_exp);
            for (int i = 0; i < NB; i++) exp_w.push_back({(i == NB - 1), 32'(wbase + i)});
        end
        exp_ar.push_back(ra_exp);
        exp_line.push_back(new_line);
        miss = 1'b1; write_back = wb; raddr = ra; waddr = wa; cacheline_old = old_line;
        tick();
        chk("busy_after_miss", LW'(busy), LW'(1));
        raddr = ~ra; waddr = ~wa; cacheline_old = ~old_line; write_back = ~wb;
        if (wb) begin
            n = 0;
            while (!awvalid && n < 20) begin tick(); n++; end
            if (!awvalid) fail_now("timeout_awvalid", 32'(n));
            repeat (stall) tick();
            awready = 1'b1; tick(); awready = 1'b0;
            repeat (stall) tick();
            wready = 1'b1; n = 0;
            do begin done = wvalid && wlast; tick(); n++; end while (!done && n < 60);
            if (!done) fail_now("timeout_wlast", 32'(n));
            wready = 1'b0;
            repeat (2) tick();
            bvalid = 1'b1; bresp = 2'b00; n = 0;
            do begin done = bready; tick(); n++; end while (!done && n < 20);
            if (!done) fail_now("timeout_bready", 32'(n));
            bvalid = 1'b0;
        end
        n = 0;
        while (!arvalid && n < 20) begin tick(); n++; end
        if (!arvalid) fail_now("timeout_arvalid", 32'(n));
        repeat (stall) tick();
        arready = 1'b1; tick(); arready = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            rvalid = 1'b1; rdata = 32'(rbase + i); rlast = (i == NB - 1);
            rresp = (i == err_beat) ? 2'b10 : 2'b00;
            n = 0;
            do begin done = rready; tick(); n++; end while (!done && n < 20);
            if (!done) fail_now("timeout_rready", 32'(n));
            rvalid = 1'b0;
        end
        rlast = 1'b0; rresp = 2'b00;
        chk("refresh_after_rlast", LW'(refresh), LW'(1));
        tick();
        chk("refresh_one_cycle", LW'(refresh), LW'(0));
        miss = 1'b0; write_back = 1'b0;
        tick();
        chk("idle_after_stale_miss", LW'({busy, arvalid, awvalid}), LW'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc;
        #23;
        chk("rst_valids", LW'({awvalid, wvalid, arvalid, bready, rready}), LW'(0));
        chk("rst_refresh_busy", LW'({refresh, busy}), LW'(0));
        chk("rst_line", cacheline_new, LW'(0));
        chk("rst_bus_err", LW'(bus_err), LW'(0));
        chk("const_fields", LW'({arlen, awlen, wstrb}), LW'({8'd15, 8'd15, 4'hF}));
        tick(); resetn = 1'b1; tick();

        // Clean fill
        run_txn(1'b0, 32'h1000_0044, 32'h1000_0040, 32'h0, 32'h0, 0, 32'hA0, 0, 1'b0, -1);
        // Dirty evict then fill
        run_txn(1'b1, 32'h1000_0044, 32'h1000_0040, 32'h2000_0080, 32'h2000_0080,
                0, 32'hA0, 0, 1'b0, -1);
        // Backpressure on AW/W/AR plus random R gaps
        run_txn(1'b1, 32'h3000_13FF, 32'h3000_13C0, 32'h2000_00BC, 32'h2000_0080,
                32'h100, 32'hA0, 3, 1'b1, -1);
        // Stale miss held through DONE: exactly one refresh, nothing restarts
        rc = refresh_cnt;
        repeat (4) tick();
        chk("no_restart_arvalid", LW'({arvalid, awvalid, busy}), LW'(0));
        chk("refresh_count", LW'(refresh_cnt - rc), LW'(0));
        chk("bus_err_clean", LW'(bus_err), LW'(0));

        // Reset during the write burst while beat 7 is presented
        exp_aw.push_back(32'h4000_0000);
        for (int i = 0; i < 7; i++) exp_w.push_back({1'b0, 32'(32'h500 + i)});
        miss = 1'b1; write_back = 1'b1; waddr = 32'h4000_0004; raddr = 32'h4100_0000;
        for (int i = 0; i < NB; i++) cacheline_old[32*i +: 32] = 32'(32'h500 + i);
        tick(); miss = 1'b0; write_back = 1'b0;
        awready = 1'b1; tick(); awready = 1'b0;
        wready = 1'b1; repeat (7) tick(); wready = 1'b0;
        chk("wdata_beat7", LW'(wdata), LW'(32'h507));
        #2 resetn = 1'b0;
        #1;
        chk("rst_async_wvalid", LW'(wvalid), LW'(0));
        chk("rst_async_busy_refresh", LW'({busy, refresh}), LW'(0));
        chk("w_queue_drained", LW'(exp_w.size()), LW'(0));
        tick(); resetn = 1'b1; tick();
        run_txn(1'b1, 32'h5000_0010, 32'h5000_0000, 32'h6000_0050, 32'h6000_0040,
                32'h600, 32'hC0, 1, 1'b0, -1);

        // Response error on beat 3, then an error-free fill
        run_txn(1'b0, 32'h7000_0000, 32'h7000_0000, 32'h0, 32'h0, 0, 32'hD0, 0, 1'b0, 3);
        chk("bus_err_set", LW'(bus_err), LW'(ERR_EN));
        run_txn(1'b0, 32'h7000_0040, 32'h7000_0040, 32'h0, 32'h0, 0, 32'hE0, 0, 1'b1, -1);
        chk("bus_err_sticky", LW'(bus_err), LW'(ERR_EN));

        repeat (3) tick();
        chk("queues_empty", LW'(exp_aw.size() + exp_w.size() + exp_ar.size() + exp_line.size()),
            LW'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
